// File: rtl/axi_chnl_align_ctrl.sv
// Per-channel AXI link bring-up: synchronises and debounces the x/y/z delay
// configuration, then walks each channel through delay -> marker alignment.
module axi_chnl_align_ctrl #(
  parameter int NUM_CHNL   = 2,
  parameter int DELAY_W    = 16,
  parameter int RATE       = 2,
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr,
  input  logic [31:0]          i_delay_x_value,
  input  logic [31:0]          i_delay_y_value,
  input  logic [31:0]          i_delay_z_value,
  input  logic [NUM_CHNL-1:0]  sl_tx_transfer_en,
  input  logic [NUM_CHNL-1:0]  ms_tx_transfer_en,
  input  logic [NUM_CHNL-1:0]  rx_align_marker,
  input  logic [TIMEOUT_W-1:0] align_timeout,
  output logic [DELAY_W-1:0]   delay_x_value,
  output logic [DELAY_W-1:0]   delay_y_value,
  output logic [DELAY_W-1:0]   delay_z_value,
  output logic                 delay_update,
  output logic [NUM_CHNL-1:0]  chnl_align_done,
  output logic [NUM_CHNL-1:0]  chnl_align_error,
  output logic                 ca_align_done,
  output logic                 ca_align_error
);

  localparam int SHIFT  = $clog2(RATE);
  localparam int STAB_W = $clog2(STABLE_CNT + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CNT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DLY,
    ST_WAIT_MRK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Index 2 = x, 1 = y, 0 = z throughout the config path.
  logic [2:0][DELAY_W-1:0] cfg_raw;
  logic [2:0][DELAY_W-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [2:0][DELAY_W-1:0] shadow_q, shadow_d;
  logic [2:0][DELAY_W-1:0] dly_out_q, dly_out_d;
  logic [STAB_W-1:0]       stab_q, stab_d;
  logic                    update_q, update_d;
  logic                    cfg_changing;
  logic                    cfg_accept;

  assign cfg_raw = {i_delay_x_value[DELAY_W-1:0],
                    i_delay_y_value[DELAY_W-1:0],
                    i_delay_z_value[DELAY_W-1:0]};

  if (DELAY_W < 32) begin : g_unused_cfg
    logic unused_cfg_hi;
    assign unused_cfg_hi = ^{i_delay_x_value[31:DELAY_W],
                             i_delay_y_value[31:DELAY_W],
                             i_delay_z_value[31:DELAY_W]};
  end

  // A value is only accepted while it is still stable in the current cycle,
  // so a fresh change can never slip through on a saturated counter.
  always_comb begin
    s1_d         = cfg_raw;
    s2_d         = s1_q;
    s3_d         = s2_q;
    shadow_d     = shadow_q;
    dly_out_d    = dly_out_q;
    update_d     = 1'b0;
    cfg_changing = (s2_q != s3_q);
    cfg_accept   = !cfg_changing && (stab_q == STAB_MAX) && (s2_q != shadow_q);

    if (cfg_changing) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
    end else begin
      stab_d = stab_q;
    end

    if (cfg_accept) begin
      shadow_d = s2_q;
      update_d = 1'b1;
      for (int k = 0; k < 3; k++) begin
        dly_out_d[k] = s2_q[k] >> SHIFT;
      end
    end
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      shadow_q  <= '0;
      dly_out_q <= '0;
      stab_q    <= '0;
      update_q  <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      shadow_q  <= shadow_d;
      dly_out_q <= dly_out_d;
      stab_q    <= stab_d;
      update_q  <= update_d;
    end
  end

  assign delay_x_value = dly_out_q[2];
  assign delay_y_value = dly_out_q[1];
  assign delay_z_value = dly_out_q[0];
  assign delay_update  = update_q;

  for (genvar i = 0; i < NUM_CHNL; i++) begin : g_chnl
    state_t               state_q, state_d;
    logic [DELAY_W-1:0]   dly_cnt_q, dly_cnt_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 online;
    logic                 tmo_hit;

    assign online  = sl_tx_transfer_en[i] & ms_tx_transfer_en[i];
    assign tmo_hit = (align_timeout != '0) &&
                     (tmo_cnt_q == align_timeout - TIMEOUT_W'(1));

    // Losing either transfer enable drops the channel back to IDLE from
    // any state, ahead of every other transition.
    always_comb begin
      state_d   = state_q;
      dly_cnt_d = dly_cnt_q;
      tmo_cnt_d = tmo_cnt_q;

      if (state_q != ST_IDLE && !online) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (online) begin
              state_d   = ST_WAIT_DLY;
              dly_cnt_d = dly_out_q[2];
            end
          end
          ST_WAIT_DLY: begin
            if (dly_cnt_q == '0) begin
              state_d   = ST_WAIT_MRK;
              tmo_cnt_d = '0;
            end else begin
              dly_cnt_d = dly_cnt_q - DELAY_W'(1);
            end
          end
          ST_WAIT_MRK: begin
            if (rx_align_marker[i]) begin
              state_d = ST_DONE;
            end else if (tmo_hit) begin
              state_d = ST_ERR;
            end else begin
              tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
            end
          end
          ST_DONE: state_d = ST_DONE;
          ST_ERR:  state_d = ST_ERR;
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
        state_q   <= ST_IDLE;
        dly_cnt_q <= '0;
        tmo_cnt_q <= '0;
      end else begin
        state_q   <= state_d;
        dly_cnt_q <= dly_cnt_d;
        tmo_cnt_q <= tmo_cnt_d;
      end
    end

    assign chnl_align_done[i]  = (state_q == ST_DONE);
    assign chnl_align_error[i] = (state_q == ST_ERR);
  end

  assign ca_align_done  = &chnl_align_done;
  assign ca_align_error = |chnl_align_error;

endmodule

// File: tb/tb_axi_chnl_align_ctrl.sv
// Self-checking bench for axi_chnl_align_ctrl: directed bring-up scenarios
// followed by a randomized run, all checked against a behavioural model.
module tb_axi_chnl_align_ctrl;

   localparam int NUM_CHNL   = 2;
   localparam int DELAY_W    = 16;
   localparam int RATE       = 2;
   localparam int STABLE_CNT = 4;
   localparam int TIMEOUT_W  = 16;
   localparam int SHIFT      = 1;
   localparam int WIN        = STABLE_CNT + 4;

   logic                 clk_wr;
   logic                 rst_wr;
   logic [31:0]          i_delay_x_value;
   logic [31:0]          i_delay_y_value;
   logic [31:0]          i_delay_z_value;
   logic [NUM_CHNL-1:0]  sl_tx_transfer_en;
   logic [NUM_CHNL-1:0]  ms_tx_transfer_en;
   logic [NUM_CHNL-1:0]  rx_align_marker;
   logic [TIMEOUT_W-1:0] align_timeout;
   logic [DELAY_W-1:0]   delay_x_value;
   logic [DELAY_W-1:0]   delay_y_value;
   logic [DELAY_W-1:0]   delay_z_value;
   logic                 delay_update;
   logic [NUM_CHNL-1:0]  chnl_align_done;
   logic [NUM_CHNL-1:0]  chnl_align_error;
   logic                 ca_align_done;
   logic                 ca_align_error;

   axi_chnl_align_ctrl #(
      .NUM_CHNL(NUM_CHNL), .DELAY_W(DELAY_W), .RATE(RATE),
      .STABLE_CNT(STABLE_CNT), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clk_wr(clk_wr), .rst_wr(rst_wr),
      .i_delay_x_value(i_delay_x_value), .i_delay_y_value(i_delay_y_value),
      .i_delay_z_value(i_delay_z_value),
      .sl_tx_transfer_en(sl_tx_transfer_en), .ms_tx_transfer_en(ms_tx_transfer_en),
      .rx_align_marker(rx_align_marker), .align_timeout(align_timeout),
      .delay_x_value(delay_x_value), .delay_y_value(delay_y_value),
      .delay_z_value(delay_z_value), .delay_update(delay_update),
      .chnl_align_done(chnl_align_done), .chnl_align_error(chnl_align_error),
      .ca_align_done(ca_align_done), .ca_align_error(ca_align_error)
   );

   // Free-running clock, 10 time units per period.
   initial clk_wr = 1'b0;
   always #5 clk_wr = ~clk_wr;

   int errors = 0;
   int checks = 0;

   // Model state: the config is accepted once the last STABLE_CNT+2 sampled
   // values (ending two edges back) agree and differ from the last accepted one.
   logic [3*DELAY_W-1:0] hist[$];
   logic [3*DELAY_W-1:0] mShadow;
   logic [DELAY_W-1:0]   mDx, mDy, mDz;
   logic                 mUpd;
   int                   mMode[NUM_CHNL];
   int                   mSpent[NUM_CHNL];
   int                   mDly[NUM_CHNL];
   int                   mWait[NUM_CHNL];

   logic [NUM_CHNL-1:0]  rSl, rMs, rMrk;

   // Advance the reference model by one clock edge using the inputs that were
   // stable across that edge; channel logic sees the pre-edge delay value.
   task automatic modelStep();
      logic [3*DELAY_W-1:0] cand;
      bit stable;
      int len;
      if (rst_wr) begin
         hist.delete();
         for (int k = 0; k < 3; k++) hist.push_back('0);
         mShadow = '0;
         mDx = '0; mDy = '0; mDz = '0;
         mUpd = 1'b0;
         for (int c = 0; c < NUM_CHNL; c++) begin
            mMode[c] = 0; mSpent[c] = 0; mDly[c] = 0; mWait[c] = 0;
         end
      end else begin
         for (int c = 0; c < NUM_CHNL; c++) begin
            if (mMode[c] != 0 && !(sl_tx_transfer_en[c] && ms_tx_transfer_en[c])) begin
               mMode[c] = 0;
            end else if (mMode[c] == 0) begin
               if (sl_tx_transfer_en[c] && ms_tx_transfer_en[c]) begin
                  mMode[c] = 1; mDly[c] = int'(mDx); mSpent[c] = 0;
               end
            end else if (mMode[c] == 1) begin
               mSpent[c]++;
               if (mSpent[c] == mDly[c] + 1) begin
                  mMode[c] = 2; mWait[c] = 0;
               end
            end else if (mMode[c] == 2) begin
               if (rx_align_marker[c]) begin
                  mMode[c] = 3;
               end else begin
                  mWait[c]++;
                  if (align_timeout != 0 && mWait[c] == int'(align_timeout)) mMode[c] = 4;
               end
            end
         end
         hist.push_back({i_delay_x_value[DELAY_W-1:0], i_delay_y_value[DELAY_W-1:0],
                         i_delay_z_value[DELAY_W-1:0]});
         if (hist.size() > WIN) void'(hist.pop_front());
         len = hist.size();
         mUpd = 1'b0;
         if (len >= WIN) begin
            cand = hist[len-3];
            stable = 1;
            for (int k = len - WIN; k <= len - 3; k++) if (hist[k] !== cand) stable = 0;
            if (stable && cand !== mShadow) begin
               mShadow = cand;
               mDx = cand[3*DELAY_W-1:2*DELAY_W] >> SHIFT;
               mDy = cand[2*DELAY_W-1:DELAY_W] >> SHIFT;
               mDz = cand[DELAY_W-1:0] >> SHIFT;
               mUpd = 1'b1;
            end
         end
      end
   endtask

   task automatic checkValue(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compare every output against the model.
   task automatic checkOutput();
      logic [NUM_CHNL-1:0] expDone, expErr;
      for (int c = 0; c < NUM_CHNL; c++) begin
         expDone[c] = (mMode[c] == 3);
         expErr[c]  = (mMode[c] == 4);
      end
      checkValue("delay_x", int'(delay_x_value), int'(mDx));
      checkValue("delay_y", int'(delay_y_value), int'(mDy));
      checkValue("delay_z", int'(delay_z_value), int'(mDz));
      checkValue("delay_update", int'(delay_update), int'(mUpd));
      checkValue("chnl_done", int'(chnl_align_done), int'(expDone));
      checkValue("chnl_error", int'(chnl_align_error), int'(expErr));
      checkValue("ca_done", int'(ca_align_done), int'(&expDone));
      checkValue("ca_error", int'(ca_align_error), int'(|expErr));
   endtask

   task automatic applyStimulus(input logic rst, input logic [NUM_CHNL-1:0] sl,
                                input logic [NUM_CHNL-1:0] ms, input logic [NUM_CHNL-1:0] mrk);
      rst_wr            = rst;
      sl_tx_transfer_en = sl;
      ms_tx_transfer_en = ms;
      rx_align_marker   = mrk;
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_wr);
         modelStep();
         @(negedge clk_wr);
         checkOutput();
      end
   endtask

   initial begin
      i_delay_x_value = '0; i_delay_y_value = '0; i_delay_z_value = '0;
      align_timeout = '0;
      applyStimulus(1'b1, '0, '0, '0);
      tick(3);
      applyStimulus(1'b0, '0, '0, '0);
      tick(10);
      checkValue("idle_update", int'(delay_update), 0);
      checkValue("idle_done", int'(chnl_align_done), 0);

      // Delay x steps to 40: scaled value 20 appears after edge t+7.
      i_delay_x_value = 32'd40;
      tick(7);
      checkValue("x_before", int'(delay_x_value), 0);
      checkValue("upd_before", int'(delay_update), 0);
      tick(1);
      checkValue("x_after", int'(delay_x_value), 20);
      checkValue("upd_pulse", int'(delay_update), 1);
      tick(1);
      checkValue("upd_one_cycle", int'(delay_update), 0);

      // Fast toggling of y never settles long enough to be accepted.
      for (int k = 0; k < 10; k++) begin
         i_delay_y_value = (k % 2 == 0) ? 32'd6 : 32'd0;
         tick(2);
      end
      tick(10);
      checkValue("y_toggle", int'(delay_y_value), 0);

      i_delay_x_value = 32'd6;
      tick(10);
      checkValue("x_three", int'(delay_x_value), 3);

      // Channel 0: 1 edge to WAIT_DLY, 4 cycles of delay, marker 2 cycles later.
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00);
      tick(5);
      tick(2);
      checkValue("ch0_pre_done", int'(chnl_align_done[0]), 0);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b01);
      tick(1);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00);
      checkValue("ch0_done", int'(chnl_align_done[0]), 1);
      checkValue("ca_done_partial", int'(ca_align_done), 0);
      applyStimulus(1'b0, 2'b11, 2'b11, 2'b00);
      tick(5);
      applyStimulus(1'b0, 2'b11, 2'b11, 2'b10);
      tick(1);
      applyStimulus(1'b0, 2'b11, 2'b11, 2'b00);
      checkValue("ca_done_all", int'(ca_align_done), 1);

      // Timeout of 5 with no marker.
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
      align_timeout = 16'd5;
      tick(1);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00);
      tick(5);
      tick(4);
      checkValue("tmo_not_yet", int'(chnl_align_error[0]), 0);
      tick(1);
      checkValue("tmo_err", int'(chnl_align_error[0]), 1);
      checkValue("ca_err", int'(ca_align_error), 1);
      applyStimulus(1'b0, 2'b01, 2'b00, 2'b00);
      tick(1);
      checkValue("err_cleared", int'(chnl_align_error[0]), 0);

      // Marker arriving on the timeout cycle wins.
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00);
      tick(9);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b01);
      tick(1);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00);
      checkValue("coinc_done", int'(chnl_align_done[0]), 1);
      checkValue("coinc_err", int'(chnl_align_error[0]), 0);

      // Dropping online during WAIT_DLY returns to IDLE without completing.
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
      tick(1);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00);
      tick(2);
      applyStimulus(1'b0, 2'b00, 2'b01, 2'b01);
      tick(6);
      checkValue("drop_no_done", int'(chnl_align_done[0]), 0);

      // Reset while in DONE clears everything on the next edge.
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b00);
      tick(5);
      applyStimulus(1'b0, 2'b01, 2'b01, 2'b01);
      tick(1);
      checkValue("pre_rst_done", int'(chnl_align_done[0]), 1);
      applyStimulus(1'b1, 2'b01, 2'b01, 2'b00);
      tick(1);
      checkValue("rst_done", int'(chnl_align_done[0]), 0);
      checkValue("rst_delay_x", int'(delay_x_value), 0);
      tick(1);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
      tick(2);

      // Randomized run against the model.
      rSl = '0; rMs = '0;
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < NUM_CHNL; c++) begin
            if ($urandom_range(0, 15) == 0) rSl[c] = ~rSl[c];
            if ($urandom_range(0, 15) == 0) rMs[c] = ~rMs[c];
            rMrk[c] = ($urandom_range(0, 5) == 0);
         end
         if ($urandom_range(0, 39) == 0)
            i_delay_x_value = ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 63);
         if ($urandom_range(0, 39) == 0)
            i_delay_y_value = ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 63);
         if ($urandom_range(0, 39) == 0)
            i_delay_z_value = ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 63);
         if ($urandom_range(0, 99) == 0) align_timeout = 16'($urandom_range(0, 12));
         applyStimulus(($urandom_range(0, 299) == 0), rSl, rMs, rMrk);
         tick(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
